mem_access_unit: RTL

Bus initiator for the data-memory interface. It accepts one load/store request at a time from the core, checks alignment, and drives the IO bus (ReadEnable/WriteEnable/ByteEnable/Address/WriteData) for the address-decoded memory blocks. On loads it holds the bus for the memory read latency, captures the word, then extracts and sign- or zero-extends the addressed byte or half. Sits between the core's MEM stage (or multicycle controller) and the memory interface.

---
 rtl/mem_access_unit_pkg.sv | 21 ++
 rtl/mem_align.sv | 65 ++++++
 rtl/mem_access_unit.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared constants for the data-memory access unit: RV32I load/store width
// codes and the bus-initiator FSM state encoding.
package mem_access_unit_pkg;

  localparam logic [2:0] FUNCT3_LB  = 3'b000;
  localparam logic [2:0] FUNCT3_LH  = 3'b001;
  localparam logic [2:0] FUNCT3_LW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;
  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic shared by loads and stores: legality, byte enables,
// store-data replication and load-data extraction with sign/zero extension.
module mem_align
  import mem_access_unit_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addrLo_i,
  input  logic [31:0] wData_i,
  input  logic [31:0] rWord_i,
  output logic        legal_o,
  output logic [3:0]  byteEn_o,
  output logic [31:0] wDataRep_o,
  output logic [31:0] rDataExt_o
);

  logic        isHalf;
  logic        isWord;
  logic [31:0] shifted;

  assign isHalf  = (funct3_i[1:0] == FUNCT3_SH[1:0]);
  assign isWord  = (funct3_i[1:0] == FUNCT3_SW[1:0]);
  assign shifted = rWord_i >> {addrLo_i, 3'b000};

  // 011 and 11x are undefined widths regardless of direction.
  assign legal_o = !((funct3_i == 3'b011) ||
                     (funct3_i[2:1] == 2'b11) ||
                     (isHalf && addrLo_i[0]) ||
                     (isWord && (addrLo_i != 2'b00)));

  always_comb begin
    byteEn_o   = 4'b0000;
    wDataRep_o = 32'h0000_0000;
    case (funct3_i[1:0])
      FUNCT3_SB[1:0]: begin
        byteEn_o   = 4'b0001 << addrLo_i;
        wDataRep_o = {4{wData_i[7:0]}};
      end
      FUNCT3_SH[1:0]: begin
        byteEn_o   = 4'b0011 << {addrLo_i[1], 1'b0};
        wDataRep_o = {2{wData_i[15:0]}};
      end
      FUNCT3_SW[1:0]: begin
        byteEn_o   = 4'b1111;
        wDataRep_o = wData_i;
      end
      default: begin
        byteEn_o   = 4'b0000;
        wDataRep_o = 32'h0000_0000;
      end
    endcase
  end

  always_comb begin
    rDataExt_o = shifted;
    case (funct3_i)
      FUNCT3_LB:  rDataExt_o = {{24{shifted[7]}}, shifted[7:0]};
      FUNCT3_LH:  rDataExt_o = {{16{shifted[15]}}, shifted[15:0]};
      FUNCT3_LBU: rDataExt_o = {24'h000000, shifted[7:0]};
      FUNCT3_LHU: rDataExt_o = {16'h0000, shifted[15:0]};
      FUNCT3_LW:  rDataExt_o = shifted;
      default:    rDataExt_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store bus initiator: registers the request onto the
// IO bus, waits out the read latency and returns the extended load result.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic        iReq,
  input  logic        iWrite,
  input  logic [2:0]  iFunct3,
  input  logic [31:0] iAddr,
  input  logic [31:0] iWData,
  output logic        oBusy,
  output logic        oDone,
  output logic        oFault,
  output logic [31:0] oRData,
  output logic        oReadEnable,
  output logic        oWriteEnable,
  output logic [3:0]  oByteEnable,
  output logic [31:0] oAddress,
  output logic [31:0] oWriteData,
  input  logic [31:0] iReadData
);

  localparam logic [2:0] RdLat = 3'(RD_LAT);

  state_e      state_q;
  logic [2:0]  cnt_q;
  logic [2:0]  cnt_d;
  logic [2:0]  funct3_q;
  logic [1:0]  addrLo_q;
  logic [2:0]  funct3Sel;
  logic [1:0]  addrLoSel;
  logic        legal;
  logic [3:0]  byteEn;
  logic [31:0] wDataRep;
  logic [31:0] rDataExt;

  // The align block sees the live request while idle and the latched one during a read.
  assign funct3Sel = (state_q == ST_IDLE) ? iFunct3 : funct3_q;
  assign addrLoSel = (state_q == ST_IDLE) ? iAddr[1:0] : addrLo_q;
  assign cnt_d     = cnt_q + 3'd1;

  mem_align uAlign (
    .funct3_i   (funct3Sel),
    .addrLo_i   (addrLoSel),
    .wData_i    (iWData),
    .rWord_i    (iReadData),
    .legal_o    (legal),
    .byteEn_o   (byteEn),
    .wDataRep_o (wDataRep),
    .rDataExt_o (rDataExt)
  );

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 3'd0;
      funct3_q     <= 3'd0;
      addrLo_q     <= 2'd0;
      oBusy        <= 1'b0;
      oDone        <= 1'b0;
      oFault       <= 1'b0;
      oRData       <= 32'h0;
      oReadEnable  <= 1'b0;
      oWriteEnable <= 1'b0;
      oByteEnable  <= 4'b0000;
      oAddress     <= 32'h0;
      oWriteData   <= 32'h0;
    end else begin
      oDone  <= 1'b0;
      oFault <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          oBusy        <= 1'b0;
          oReadEnable  <= 1'b0;
          oWriteEnable <= 1'b0;
          oByteEnable  <= 4'b0000;
          oAddress     <= 32'h0;
          oWriteData   <= 32'h0;
          if (iReq) begin
            funct3_q <= iFunct3;
            addrLo_q <= iAddr[1:0];
            cnt_q    <= 3'd0;
            oBusy    <= 1'b1;
            if (!legal) begin
              state_q <= ST_FAULT;
              oFault  <= 1'b1;
            end else if (iWrite) begin
              state_q      <= ST_WRITE;
              oWriteEnable <= 1'b1;
              oAddress     <= iAddr;
              oByteEnable  <= byteEn;
              oWriteData   <= wDataRep;
            end else begin
              state_q     <= ST_READ;
              oReadEnable <= 1'b1;
              oAddress    <= iAddr;
              oByteEnable <= byteEn;
            end
          end
        end
        ST_WRITE: begin
          state_q      <= ST_IDLE;
          oBusy        <= 1'b0;
          oDone        <= 1'b1;
          oWriteEnable <= 1'b0;
          oByteEnable  <= 4'b0000;
          oAddress     <= 32'h0;
          oWriteData   <= 32'h0;
        end
        ST_READ: begin
          if (cnt_q == RdLat) begin
            state_q     <= ST_IDLE;
            oBusy       <= 1'b0;
            oDone       <= 1'b1;
            oRData      <= rDataExt;
            oReadEnable <= 1'b0;
            oByteEnable <= 4'b0000;
            oAddress    <= 32'h0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_FAULT: begin
          state_q <= ST_IDLE;
          oBusy   <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
